// File: rtl/arith_op_scheduler_if.sv
// Request/response bundle for arith_op_scheduler: N_REQ request ports flattened into vectors,
// plus the single shared response port.
interface arith_op_scheduler_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
) ();
    localparam int ID_WIDTH = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [2*N_REQ-1:0]          req_op;
    logic [DATA_WIDTH*N_REQ-1:0] req_a;
    logic [DATA_WIDTH*N_REQ-1:0] req_b;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [DATA_WIDTH-1:0]       resp_data;
    logic [ID_WIDTH-1:0]         resp_id;
    logic                        resp_error;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_error
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_error
    );
endinterface

// File: rtl/arith_op_scheduler.sv
// Round-robin scheduler sharing one iterative divide / modulo / ceil-log2 engine between
// N_REQ requesters; one result in flight at a time.
module arith_op_scheduler #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    arith_op_scheduler_if.slave  bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    localparam int ID_WIDTH = $clog2(N_REQ);
    localparam int IW1      = ID_WIDTH + 1;
    localparam int CNT_W    = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant;
    logic                  found;
    logic [IW1-1:0]        idx_w;
    logic [IW1-1:0]        next_ptr;
    logic [1:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [ID_WIDTH-1:0]   id_q;
    logic [1:0]            op_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] err_data_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH:0]   rem_q;
    logic [DATA_WIDTH-1:0] scan_q;
    logic [DATA_WIDTH-1:0] clog_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH:0]   shifted;
    logic                  fits;
    logic [DATA_WIDTH-1:0] calc_result;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold req_valid/operands until granted; the result is held until resp_ready.

    // First asserted requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx_w = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_w = {1'b0, rr_ptr} + IW1'(i);
            if (idx_w >= IW1'(N_REQ)) idx_w = idx_w - IW1'(N_REQ);
            if (!found && bus.req_valid[idx_w[ID_WIDTH-1:0]]) begin
                grant = idx_w[ID_WIDTH-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found && reset) bus.req_ready[grant] = 1'b1;
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                sel_op = bus.req_op[2*i +: 2];
                sel_a  = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        next_ptr = {1'b0, grant} + IW1'(1);
        if (next_ptr >= IW1'(N_REQ)) next_ptr = '0;
    end

    // Restoring division step: the remainder is always below b, so it fits in DATA_WIDTH bits.
    always_comb begin
        shifted = {rem_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
        fits    = (shifted >= {1'b0, b_q});
        case (op_q)
            2'b00:   calc_result = quo_q;
            2'b01:   calc_result = rem_q[DATA_WIDTH-1:0];
            default: calc_result = clog_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            id_q           <= '0;
            op_q           <= '0;
            err_q          <= 1'b0;
            err_data_q     <= '0;
            b_q            <= '0;
            quo_q          <= '0;
            rem_q          <= '0;
            scan_q         <= '0;
            clog_q         <= '0;
            cnt_q          <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_id    <= '0;
            bus.resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id_q   <= grant;
                        op_q   <= sel_op;
                        b_q    <= sel_b;
                        rr_ptr <= next_ptr[ID_WIDTH-1:0];
                        cnt_q  <= '0;
                        quo_q  <= sel_a;
                        rem_q  <= '0;
                        clog_q <= '0;
                        // ceil(log2(a)) = index of the top set bit of (a-1), plus one; 0 for a<=1.
                        scan_q <= (sel_a > DATA_WIDTH'(1)) ? sel_a - DATA_WIDTH'(1) : '0;
                        if (sel_op == 2'b11) begin
                            err_q      <= 1'b1;
                            err_data_q <= '0;
                            state      <= RESP;
                        end else if (sel_op != 2'b10 && sel_b == '0) begin
                            err_q      <= 1'b1;
                            err_data_q <= (sel_op == 2'b00) ? '1 : sel_a;
                            state      <= RESP;
                        end else begin
                            err_q      <= 1'b0;
                            err_data_q <= '0;
                            state      <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (fits) begin
                        rem_q <= shifted - {1'b0, b_q};
                        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted;
                        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (scan_q[0]) clog_q <= DATA_WIDTH'(cnt_q) + DATA_WIDTH'(1);
                    scan_q <= scan_q >> 1;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state <= RESP;
                end
                RESP: begin
                    // First RESP cycle publishes the result; later cycles wait for the consumer.
                    if (!bus.resp_valid) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_data  <= err_q ? err_data_q : calc_result;
                        bus.resp_id    <= id_q;
                        bus.resp_error <= err_q;
                    end else if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_arith_op_scheduler.sv
// Bench for arith_op_scheduler: negedge monitor pushes expected results at every grant and
// compares them when the response transfers.
module tb_arith_op_scheduler;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int EW  = W + IDW + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    arith_op_scheduler_if #(.N_REQ(N), .DATA_WIDTH(W)) bus ();

    arith_op_scheduler #(.N_REQ(N), .DATA_WIDTH(W)) dut (
        .clock    (clk),
        .reset    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            hs_count = 0;
    logic [EW-1:0] exp_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input int port, input logic [1:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         e;
        int           r;
        e = 1'b0;
        d = '0;
        case (op)
            2'd0: if (b == 0) begin e = 1'b1; d = '1; end else d = a / b;
            2'd1: if (b == 0) begin e = 1'b1; d = a; end else d = a % b;
            2'd2: begin
                r = 0;
                while ((64'd1 << r) < {32'd0, a}) r++;
                d = W'(r);
            end
            default: begin e = 1'b1; d = '0; end
        endcase
        return {e, IDW'(port), d};
    endfunction

    // Scoreboard: push at grant, pop at response transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|bus.req_ready) begin
                check("ready_onehot", 64'($countones(bus.req_ready)), 1);
                check("ready_without_valid", 64'(bus.req_ready & ~bus.req_valid), 0);
                for (int p = 0; p < N; p++) begin
                    if (bus.req_ready[p]) begin
                        grant_log.push_back(p);
                        exp_q.push_back(model(p, bus.req_op[2*p +: 2], bus.req_a[p*W +: W],
                                              bus.req_b[p*W +: W]));
                    end
                end
                hs_count++;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("resp", 64'({bus.resp_error, bus.resp_id, bus.resp_data}), 64'(exp_v));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        bus.req_op[2*p +: 2] = op;
        bus.req_a[p*W +: W]  = a;
        bus.req_b[p*W +: W]  = b;
        bus.req_valid[p]     = 1'b1;
    endtask

    // Returns just after the handshake edge (edge 0).
    task automatic issue(input int p, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int start;
        int t;
        start = hs_count;
        t = 0;
        drive(p, op, a, b);
        while (hs_count == start && t < 200) begin
            tick();
            t++;
        end
        bus.req_valid[p] = 1'b0;
        if (hs_count == start) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int exp_lat);
        int t;
        t = 0;
        while (!bus.resp_valid && t < 100) begin
            tick();
            t++;
        end
        check("latency", 64'(t), 64'(exp_lat));
        check("busy_in_resp", 64'(busy), 1);
        check("no_ready_in_resp", 64'(bus.req_ready), 0);
        t = 0;
        while (bus.resp_valid && t < 200) begin
            tick();
            t++;
        end
        check("idle_after_resp", 64'(busy), 0);
    endtask

    task automatic run(input int p, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int lat);
        issue(p, op, a, b);
        wait_resp(lat);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        grant_log.delete();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int           t;
        int           start;
        int           p;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (3) tick();
        check("rst_resp_valid", 64'(bus.resp_valid), 0);
        check("rst_resp_data", 64'(bus.resp_data), 0);
        check("rst_resp_id", 64'(bus.resp_id), 0);
        check("rst_resp_error", 64'(bus.resp_error), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_req_ready", 64'(bus.req_ready), 0);
        rst_n = 1'b1;
        tick();

        // Single-operation results, latencies and boundaries
        run(0, 2'd0, 100, 7, 33);
        run(2, 2'd1, 100, 7, 33);
        run(1, 2'd2, 5, 0, 33);
        run(1, 2'd2, 1, 0, 33);
        run(1, 2'd2, 32'hFFFF_FFFF, 0, 33);
        run(3, 2'd2, 0, 0, 33);
        run(0, 2'd2, 1024, 0, 33);
        run(0, 2'd2, 1025, 0, 33);
        run(3, 2'd0, 32'hFFFF_FFFF, 1, 33);
        run(2, 2'd0, 5, 9, 33);
        run(0, 2'd0, 9, 0, 1);
        run(1, 2'd1, 9, 0, 1);
        run(2, 2'd3, 5, 5, 1);
        for (int i = 0; i < 6; i++) begin
            p  = $urandom_range(0, N - 1);
            op = 2'($urandom_range(0, 2));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 1;
            run(p, op, a, b, 33);
        end

        // All ports requesting continuously: round-robin from pointer 0
        pulse_reset();
        drive(0, 2'd0, 1000, 10);
        drive(1, 2'd1, 1000, 7);
        drive(2, 2'd2, 1000, 0);
        drive(3, 2'd3, 1, 1);
        t = 0;
        while (grant_log.size() < 5 && t < 400) begin
            tick();
            t++;
        end
        bus.req_valid = '0;
        check("rr_grant_count", 64'(grant_log.size()), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("rr_grant_order", 64'(grant_log[i]), 64'(i % N));
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        check("rr_drain", 64'(exp_q.size()), 0);
        repeat (2) tick();

        // Response backpressure: outputs held, no grants while stalled
        bus.resp_ready = 1'b0;
        issue(1, 2'd0, 50, 5);
        t = 0;
        while (!bus.resp_valid && t < 100) begin
            tick();
            t++;
        end
        check("stall_latency", 64'(t), 33);
        drive(0, 2'd1, 77, 10);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 64'(bus.resp_valid), 1);
            check("stall_data", 64'(bus.resp_data), 10);
            check("stall_id", 64'(bus.resp_id), 1);
            check("stall_error", 64'(bus.resp_error), 0);
            check("stall_req_ready", 64'(bus.req_ready), 0);
            tick();
        end
        start = hs_count;
        bus.resp_ready = 1'b1;
        tick();
        check("gap_busy", 64'(busy), 0);
        check("gap_state", 64'(state_dbg), 0);
        check("gap_resp_valid", 64'(bus.resp_valid), 0);
        t = 0;
        while (hs_count == start && t < 20) begin
            tick();
            t++;
        end
        bus.req_valid[0] = 1'b0;
        check("post_stall_grant", 64'(hs_count - start), 1);
        wait_resp(33);

        // Reset in the middle of CALC
        issue(2, 2'd0, 1000, 3);
        repeat (10) tick();
        check("calc_state", 64'(state_dbg), 1);
        rst_n = 1'b0;
        drive(1, 2'd2, 64, 0);
        drive(3, 2'd2, 7, 0);
        #1;
        check("abort_resp_valid", 64'(bus.resp_valid), 0);
        check("abort_resp_data", 64'(bus.resp_data), 0);
        check("abort_resp_id", 64'(bus.resp_id), 0);
        check("abort_resp_error", 64'(bus.resp_error), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_req_ready", 64'(bus.req_ready), 0);
        exp_q.delete();
        grant_log.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        t = 0;
        while (grant_log.size() < 1 && t < 20) begin
            tick();
            t++;
        end
        bus.req_valid[1] = 1'b0;
        t = 0;
        while (grant_log.size() < 2 && t < 200) begin
            tick();
            t++;
        end
        bus.req_valid[3] = 1'b0;
        check("reset_grant_count", 64'(grant_log.size()), 2);
        if (grant_log.size() >= 2) begin
            check("reset_first_grant", 64'(grant_log[0]), 1);
            check("reset_second_grant", 64'(grant_log[1]), 3);
        end
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check("final_queue_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
